// File: rtl/nibble_pkg.sv
// Shared constants and types for the nibble controller: ALU opcodes, instruction ops,
// FSM states and operand-B source select.
package nibble_pkg;

  localparam int PC_W_DEF = 8;

  localparam logic [2:0] ALU_OUT = 3'd0;
  localparam logic [2:0] ALU_CMP = 3'd1;
  localparam logic [2:0] ALU_LD  = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;

  typedef enum logic [3:0] {
    OP_LIT  = 4'h0, OP_IN   = 4'h1, OP_LD   = 4'h2, OP_ST   = 4'h3,
    OP_OUT  = 4'h4, OP_CMPI = 4'h5, OP_CMPM = 4'h6, OP_ADDI = 4'h7,
    OP_ADDM = 4'h8, OP_NORI = 4'h9, OP_NORM = 4'hA, OP_JMP  = 4'hB,
    OP_JC   = 4'hC, OP_JNC  = 4'hD, OP_JZ   = 4'hE, OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_MEM, S_EXEC, S_FETCH2, S_JUMP, S_HALT
  } state_e;

  localparam logic [1:0] BSEL_ARG = 2'd0;
  localparam logic [1:0] BSEL_IN  = 2'd1;
  localparam logic [1:0] BSEL_MEM = 2'd2;

endpackage

// File: rtl/nibble_decode.sv
// Combinational instruction decoder: maps the 4-bit op to ALU opcode, operand-B source
// and the per-instruction write/read/jump controls.
module nibble_decode
  import nibble_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_opcode,
  output logic [1:0] bsel,
  output logic       acc_we,
  output logic       flag_we,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       is_jump
);

  always_comb begin
    alu_opcode = ALU_OUT;
    bsel       = BSEL_ARG;
    acc_we     = 1'b0;
    flag_we    = 1'b0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    is_jump    = 1'b0;
    case (op_e'(op))
      OP_LIT:  begin alu_opcode = ALU_LD;  acc_we = 1'b1; end
      OP_IN:   begin alu_opcode = ALU_LD;  bsel = BSEL_IN;  acc_we = 1'b1; end
      OP_LD:   begin alu_opcode = ALU_LD;  bsel = BSEL_MEM; acc_we = 1'b1; mem_rd = 1'b1; end
      OP_ST:   mem_we = 1'b1;
      OP_OUT:  alu_opcode = ALU_OUT;
      OP_CMPI: begin alu_opcode = ALU_CMP; flag_we = 1'b1; end
      OP_CMPM: begin alu_opcode = ALU_CMP; bsel = BSEL_MEM; flag_we = 1'b1; mem_rd = 1'b1; end
      OP_ADDI: begin alu_opcode = ALU_ADD; acc_we = 1'b1; flag_we = 1'b1; end
      OP_ADDM: begin
        alu_opcode = ALU_ADD; bsel = BSEL_MEM; acc_we = 1'b1; flag_we = 1'b1; mem_rd = 1'b1;
      end
      OP_NORI: begin alu_opcode = ALU_NOR; acc_we = 1'b1; flag_we = 1'b1; end
      OP_NORM: begin
        alu_opcode = ALU_NOR; bsel = BSEL_MEM; acc_we = 1'b1; flag_we = 1'b1; mem_rd = 1'b1;
      end
      OP_JMP, OP_JC, OP_JNC, OP_JZ: is_jump = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/nibble_ctrl.sv
// Nibble CPU controller: fetch/decode/execute FSM around an external ALU and memories.
// Optional NIBBLE_HALT_EN makes op F stop the core until reset (otherwise op F is a NOP).
module nibble_ctrl
  import nibble_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] pmem_addr,
  input  logic [7:0]      pmem_data,
  output logic [3:0]      dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wdata,
  input  logic [3:0]      dmem_rdata,
  output logic [2:0]      alu_opcode,
  output logic [3:0]      alu_a,
  output logic [3:0]      alu_b,
  input  logic [3:0]      alu_out,
  input  logic            alu_carry,
  input  logic            alu_zero,
  input  logic [3:0]      in_port,
  output logic [3:0]      out_port,
  output logic            out_valid,
  output logic            halted
);

  state_e          state;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic [3:0]      acc;
  logic            flag_c;
  logic            flag_z;

  logic [3:0] cur_op;
  logic [1:0] bsel;
  logic       acc_we;
  logic       flag_we;
  logic       mem_rd;
  logic       mem_we;
  logic       is_jump;
  logic       taken;
  logic       halt_op;

  // In DECODE the instruction byte is still on pmem_data; afterwards it lives in IR.
  assign cur_op = (state == S_DECODE) ? pmem_data[7:4] : ir[7:4];

  nibble_decode u_decode (
    .op         (cur_op),
    .alu_opcode (alu_opcode),
    .bsel       (bsel),
    .acc_we     (acc_we),
    .flag_we    (flag_we),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .is_jump    (is_jump)
  );

  assign pmem_addr  = pc;
  assign dmem_addr  = ir[3:0];
  assign dmem_wdata = acc;
  assign alu_a      = acc;

  always_comb begin
    case (bsel)
      BSEL_IN:  alu_b = in_port;
      BSEL_MEM: alu_b = dmem_rdata;
      default:  alu_b = ir[3:0];
    endcase
  end

  always_comb begin
    case (op_e'(cur_op))
      OP_JMP:  taken = 1'b1;
      OP_JC:   taken = flag_c;
      OP_JNC:  taken = ~flag_c;
      OP_JZ:   taken = flag_z;
      default: taken = 1'b0;
    endcase
  end

  // Strobes are decoded from EXEC and masked by reset so a store cannot land mid-reset.
  assign dmem_we   = (state == S_EXEC) && mem_we && !reset;
  assign out_valid = (state == S_EXEC) && (cur_op == OP_OUT) && !reset;

`ifdef NIBBLE_HALT_EN
  assign halt_op = (cur_op == OP_HALT);
  assign halted  = (state == S_HALT);
`else
  assign halt_op = 1'b0;
  assign halted  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
      out_port <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= pmem_data;
          pc <= pc + PC_W'(1);
          if (is_jump)     state <= S_FETCH2;
          else if (mem_rd) state <= S_MEM;
          else             state <= S_EXEC;
        end
        S_MEM: state <= S_EXEC;
        S_EXEC: begin
          if (acc_we) acc <= alu_out;
          if (flag_we) begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
          end
          if (cur_op == OP_OUT) out_port <= acc;
          state <= halt_op ? S_HALT : S_FETCH;
        end
        S_FETCH2: state <= S_JUMP;
        S_JUMP: begin
          pc    <= taken ? PC_W'(pmem_data) : pc + PC_W'(1);
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_ctrl.sv
// Directed bench for nibble_ctrl: table of small programs plus hand-timed reset,
// latency, wrap and halt sequences. Program/data memories and ALU are modelled here.
module tb_nibble_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pmem_addr;
  logic [7:0] pmem_data;
  logic [3:0] dmem_addr;
  logic       dmem_we;
  logic [3:0] dmem_wdata;
  logic [3:0] dmem_rdata;
  logic [2:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_out;
  logic       alu_carry;
  logic       alu_zero;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic       out_valid;
  logic       halted;

  int checks = 0;
  int errors = 0;

  logic [7:0] pmem [0:255];
  logic [3:0] dmem [0:15];

  always #5 clk = ~clk;

  nibble_ctrl #(.PC_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pmem_addr  (pmem_addr),
    .pmem_data  (pmem_data),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .halted     (halted)
  );

  always @(posedge clk) begin
    pmem_data <= pmem[pmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr];
  end

  // ALU: CMP carry is the borrow of a-b, ADD carry is the fifth sum bit.
  logic [4:0] alu_t;
  always_comb begin
    alu_t     = 5'd0;
    alu_out   = alu_a;
    alu_carry = 1'b0;
    case (alu_opcode)
      3'd1: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_out = alu_t[3:0]; alu_carry = alu_t[4]; end
      3'd2: alu_out = alu_b;
      3'd3: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = alu_t[3:0]; alu_carry = alu_t[4]; end
      3'd4: alu_out = ~(alu_a | alu_b);
      default: ;
    endcase
    alu_zero = (alu_out == 4'd0);
  end

  typedef struct {
    string        name;
    logic [127:0] prog;
    logic [3:0]   inp;
    logic [3:0]   exp_out;
    logic [3:0]   exp_acc;
    int           exp_pulses;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    for (int i = 0; i < 16; i++) dmem[i] = 4'h0;
  endtask

  task automatic load_prog(input logic [127:0] p);
    clear_mem();
    for (int i = 0; i < 16; i++) pmem[i] = p[127-8*i -: 8];
  endtask

  // Reset is sampled high at the last edge; the following negedge lies in cycle 1.
  task automatic start_prog();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int pulses;
    reset   = 1'b1;
    in_port = 4'h0;
    clear_mem();

    vecs[0]  = '{"lit_out",   {8'h05,8'h40,8'hB0,8'h02,{12{8'h00}}}, 4'h0, 4'h5, 4'h5, 1};
    vecs[1]  = '{"in_out",    {8'h10,8'h40,8'hB0,8'h02,{12{8'h00}}}, 4'hA, 4'hA, 4'hA, 1};
    vecs[2]  = '{"st_ld",     {8'h03,8'h37,8'h00,8'h27,8'h40,8'hB0,8'h05,{9{8'h00}}}, 4'h0, 4'h3, 4'h3, 1};
    vecs[3]  = '{"addi",      {8'h06,8'h77,8'h40,8'hB0,8'h03,{11{8'h00}}}, 4'h0, 4'hD, 4'hD, 1};
    vecs[4]  = '{"nori",      {8'h05,8'h92,8'h40,8'hB0,8'h03,{11{8'h00}}}, 4'h0, 4'h8, 4'h8, 1};
    vecs[5]  = '{"cmpi_jz",   {8'h04,8'h54,8'hE0,8'h06,8'h0F,8'h40,8'h40,8'hB0,8'h07,{7{8'h00}}},
                 4'h0, 4'h4, 4'h4, 1};
    vecs[6]  = '{"addi_jc",   {8'h0F,8'h71,8'hC0,8'h06,8'h09,8'h40,8'h02,8'h40,8'hB0,8'h08,{6{8'h00}}},
                 4'h0, 4'h2, 4'h2, 1};
    vecs[7]  = '{"jnc_not",   {8'h04,8'h55,8'hD0,8'h08,8'h07,8'h40,8'hB0,8'h06,8'h01,8'h40,8'hB0,8'h0A,
                 {4{8'h00}}}, 4'h0, 4'h7, 4'h7, 1};
    vecs[8]  = '{"jnc_taken", {8'h06,8'h55,8'hD0,8'h08,8'h07,8'h40,8'hB0,8'h06,8'h01,8'h40,8'hB0,8'h0A,
                 {4{8'h00}}}, 4'h0, 4'h1, 4'h1, 1};
    vecs[9]  = '{"ld_keeps_flags", {8'h0F,8'h71,8'h03,8'h37,8'h00,8'h27,8'hC0,8'h0C,8'h0E,8'h40,8'hB0,
                 8'h0A,8'h40,8'hB0,8'h0D,8'h00}, 4'h0, 4'h3, 4'h3, 1};
    vecs[10] = '{"addm",      {8'h09,8'h32,8'h05,8'h82,8'h40,8'hB0,8'h05,{9{8'h00}}}, 4'h0, 4'hE, 4'hE, 1};
    vecs[11] = '{"norm",      {8'h03,8'h31,8'h04,8'hA1,8'h40,8'hB0,8'h05,{9{8'h00}}}, 4'h0, 4'h8, 4'h8, 1};
    vecs[12] = '{"cmpm_jc",   {8'h02,8'h30,8'h09,8'h60,8'hC0,8'h09,8'h40,8'hB0,8'h07,8'h01,8'h40,8'hB0,
                 8'h0B,{3{8'h00}}}, 4'h0, 4'h9, 4'h9, 1};
`ifdef NIBBLE_HALT_EN
    vecs[13] = '{"op_f",      {8'hF0,8'h06,8'h40,8'hB0,8'h03,{11{8'h00}}}, 4'h0, 4'h0, 4'h0, 0};
`else
    vecs[13] = '{"op_f",      {8'hF0,8'h06,8'h40,8'hB0,8'h03,{11{8'h00}}}, 4'h0, 4'h6, 4'h6, 1};
`endif

    for (int v = 0; v < 14; v++) begin
      load_prog(vecs[v].prog);
      in_port = vecs[v].inp;
      start_prog();
      pulses = 0;
      repeat (60) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      check({vecs[v].name, "_out"},    {28'd0, out_port}, {28'd0, vecs[v].exp_out});
      check({vecs[v].name, "_acc"},    {28'd0, alu_a},    {28'd0, vecs[v].exp_acc});
      check({vecs[v].name, "_pulses"}, pulses,            vecs[v].exp_pulses);
    end

    // Reset from a non-zero state.
    load_prog({8'h0B,8'h40,8'hB0,8'h02,{12{8'h00}}});
    start_prog();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_pc",        {24'd0, pmem_addr}, 32'h0);
    check("rst_acc",       {28'd0, alu_a},     32'h0);
    check("rst_out_port",  {28'd0, out_port},  32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'h0);
    check("rst_dmem_we",   {31'd0, dmem_we},   32'h0);
    check("rst_halted",    {31'd0, halted},    32'h0);

    // out_valid pulses only in cycle 6 (EXEC of OUT).
    load_prog({8'h05,8'h40,8'hB0,8'h02,{12{8'h00}}});
    start_prog();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("out_valid_cyc%0d", k), {31'd0, out_valid}, (k == 6) ? 32'd1 : 32'd0);
    end
    check("out_port_after_pulse", {28'd0, out_port}, 32'h5);

    // ADDI carry/zero then JC to 0x20.
    load_prog({8'h0F,8'h71,8'hC0,8'h20,{12{8'h00}}});
    pmem[8'h20] = 8'hB0;
    pmem[8'h21] = 8'h20;
    start_prog();
    repeat (9) @(negedge clk);
    check("jc_fetch2_addr", {24'd0, pmem_addr}, 32'h03);
    repeat (2) @(negedge clk);
    check("jc_target", {24'd0, pmem_addr}, 32'h20);
    check("jc_acc0",   {28'd0, alu_a},     32'h0);

    // PC wrap from 0xFF.
    load_prog({8'hB0,8'hFF,{14{8'h00}}});
    pmem[8'hFF] = 8'h07;
    start_prog();
    repeat (5) @(negedge clk);
    check("wrap_at_ff", {24'd0, pmem_addr}, 32'hFF);
    repeat (3) @(negedge clk);
    check("wrap_to_00", {24'd0, pmem_addr}, 32'h00);
    check("wrap_acc",   {28'd0, alu_a},     32'h7);

    // Reset during MEM of ADDM.
    load_prog({8'h05,8'h81,{14{8'h00}}});
    dmem[1] = 4'hB;
    start_prog();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mem_rst_pc",  {24'd0, pmem_addr}, 32'h0);
    check("mem_rst_acc", {28'd0, alu_a},     32'h0);
    load_prog({8'hC0,8'h08,8'h01,8'h40,8'hB0,8'h04,8'h00,8'h00,8'h02,8'h40,8'hB0,8'h0A,{4{8'h00}}});
    start_prog();
    repeat (30) @(negedge clk);
    check("mem_rst_flags", {28'd0, out_port}, 32'h1);

    // ST in EXEC while reset asserts must not write.
    load_prog({8'h03,8'h37,{14{8'h00}}});
    start_prog();
    repeat (6) @(negedge clk);
    check("st_exec_we", {31'd0, dmem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("st_rst_we_masked", {31'd0, dmem_we}, 32'h0);
    @(negedge clk);
    check("st_rst_no_write", {28'd0, dmem[7]}, 32'h0);

    // Op F: halt (macro) or 3-cycle NOP.
    for (int i = 0; i < 256; i++) pmem[i] = 8'hF0;
    start_prog();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
`ifdef NIBBLE_HALT_EN
      if (k >= 4) begin
        check($sformatf("halt_addr_cyc%0d", k), {24'd0, pmem_addr}, 32'h1);
        check($sformatf("halted_cyc%0d", k),    {31'd0, halted},    32'h1);
      end
`else
      if ((k - 1) % 3 == 0)
        check($sformatf("nop_addr_cyc%0d", k), {24'd0, pmem_addr}, (k - 1) / 3);
      check($sformatf("nop_halted_cyc%0d", k), {31'd0, halted}, 32'h0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
